alarm_timer_multi: RTL and testbench
====================================

Name: alarm_timer_multi

Overview:
Second-generation countdown alarm controller for the lab FPGA board. It adds the following over the first generation:
- parametrised set range, tick divider, LED bar width and debounce length
- pause/resume
- a bounded snooze count with configurable snooze time
- alarm auto-timeout
- a proper asynchronous reset

It sits between the debounced board buttons and the SSD/LED drivers. It runs on the single board clock and uses clock-enable ticks only.

Parameters:
CLK_DIV, 10, CLK cycles per countdown tick (>=2)
MAX_SET, 9, maximum settable time in ticks (1..2^CNT_W-1)
CNT_W, 4, width of time counters and ssd_led_out
LED_N, 9, LED bar width
DEB_CYCLES, 3, consecutive low samples that qualify a button press
SNOOZE_TIME, 5, ticks reloaded on snooze (<=MAX_SET)
MAX_SNOOZE, 3, snoozes allowed per alarm cycle
ALARM_TIMEOUT, 20, ticks in ALARM before automatic return to IDLE

Ports:
CLK  in  1  board clock, rising edge only
RST_N  in  1  asynchronous active-low reset
start_stop_button  in  1  active-low button
set_button  in  1  active-low button
snooze_button  in  1  active-low button
ssd_led_out  out  CNT_W  remaining/set time, binary
led_out  out  LED_N  LED bar
alarm_active  out  1  high while in ALARM
snooze_left  out  $clog2(MAX_SNOOZE+1)  remaining snoozes

Behaviour:
- Clocking and reset: one clock, CLK. Reset is asynchronous and active-low (RST_N).
- Values while RST_N=0:
  - state=IDLE; all counters 0
  - ssd_led_out=0, led_out=0, alarm_active=0, snooze_left=MAX_SNOOZE
- Reset mid-operation aborts immediately. After release, the first active edge behaves as IDLE.
- Button press:
  - Input sampled low on DEB_CYCLES consecutive edges produces a 1-cycle press pulse on the following edge.
  - Only one pulse is produced per press; the input must be sampled high before the next pulse can occur.
  - Total latency from first low sample to FSM reaction is DEB_CYCLES+1 edges.
- Tick:
  - Prescaler runs only in RUN and ALARM and is cleared on entry to either state.
  - tick=1 for one cycle when prescaler==CLK_DIV-1, then the prescaler wraps to 0.
- Event priority for presses on the same cycle: start_stop > snooze > set. Lower-priority presses on that cycle are dropped.
- FSM states and transitions:
  - IDLE: clear set_time, rem, led_out; snooze_left=MAX_SNOOZE. Go to SET next cycle.
  - SET:
    - set press: set_time+1, saturating at MAX_SET; further presses are ignored.
    - rem follows set_time.
    - start_stop press with set_time>0: go to RUN.
    - start_stop press with set_time==0: ignored.
  - RUN:
    - On tick with rem>0: rem-1.
    - When rem==0 (checked each cycle): go to ALARM.
    - start_stop press: go to PAUSE.
  - PAUSE:
    - rem frozen.
    - start_stop press: go to RUN (prescaler restarts from 0).
    - set press: go to IDLE (cancel).
  - ALARM:
    - led_out toggles all bits on each tick, starting from all-ones on entry.
    - snooze press with snooze_left>0: go to SNOOZE.
    - snooze press with snooze_left==0: ignored.
    - start_stop press: go to IDLE.
    - After ALARM_TIMEOUT ticks: go to IDLE.
  - SNOOZE: one cycle. rem=SNOOZE_TIME, snooze_left-1, then go to RUN.
- Outputs:
  - ssd_led_out=rem in every state except IDLE, where it is 0.
  - led_out in SET/RUN/PAUSE = thermometer code of min(rem, LED_N), LSB-first. Example: rem=3 gives ...000111.
  - alarm_active is registered; it is high on the first cycle in ALARM.
- Width rules:
  - rem, set_time: CNT_W bits, never negative, no wrap.
  - Timeout counter: $clog2(ALARM_TIMEOUT+1) bits.

Decomposition:
- Shared package alarm_pkg:
  - state enum: IDLE, SET, RUN, PAUSE, ALARM, SNOOZE (3-bit)
  - event priority constants
  - thermometer-encode function
- Natural sub-module: button_debounce (parameter DEB_CYCLES; ports CLK, RST_N, btn_n, press). Instantiated three times.
- FSM, prescaler and counters stay in the top module.

Test Plan:
1. Reset mid-RUN with rem=4: assert RST_N=0 -> all outputs 0 and snooze_left=3 in the same cycle, without waiting for a clock edge.
2. Set range: CLK_DIV=4; press set 12 times, then start -> ssd_led_out saturates at 9. Count then reaches 0 after 36 cycles (9 ticks × 4); alarm_active=1 on the next edge.
3. Bounce and debounce: set_button low for 2 cycles then high -> no increment. Low for 10 cycles -> exactly one increment, 4 edges after the first low sample.
4. Pause/resume: rem=5; pause after 2 ticks -> ssd_led_out holds 3 for 100 cycles. Resume -> first decrement after exactly CLK_DIV cycles.
5. Snooze limit: in ALARM, snooze -> rem=5, snooze_left=2. Repeat until snooze_left=0; a fourth snooze press in ALARM is ignored and the alarm stays asserted.
6. Simultaneous events and timeout: in ALARM, start_stop and snooze pressed on the same cycle -> IDLE and snooze_left unchanged. With no press, ALARM exits to IDLE after 20 ticks; led_out toggles 20 times.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-snooze countdown alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    ALARM  = 3'd4,
    SNOOZE = 3'd5
  } state_e;

  // Encoding doubles as priority: a larger value wins on the same cycle.
  typedef enum logic [1:0] {
    EV_NONE       = 2'd0,
    EV_SET        = 2'd1,
    EV_SNOOZE     = 2'd2,
    EV_START_STOP = 2'd3
  } event_e;

  function automatic event_e pick_event(input logic ss, input logic sn, input logic st);
    if (ss) return EV_START_STOP;
    if (sn) return EV_SNOOZE;
    if (st) return EV_SET;
    return EV_NONE;
  endfunction

  // Bit idx of an LSB-first thermometer code holding `level` ones.
  function automatic logic thermo_bit(input logic [31:0] level, input logic [31:0] idx);
    return idx < level;
  endfunction

endpackage

// File: rtl/alarm_timer_multi_debounce.sv
// Button qualifier: DEB_CYCLES consecutive low samples give one registered press pulse.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned DC_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic [DC_W-1:0] cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;

  // Re-arm only after a high sample so a held button fires once.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (btn_n) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == DC_W'(DEB_CYCLES - 1)) begin
        press_d = 1'b1;
        armed_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + DC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alarm_timer_multi.sv
// Countdown alarm with set/run/pause, bounded snooze and alarm timeout; tick-enabled datapath.
module alarm_timer_multi
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 10,
  parameter int unsigned MAX_SET       = 9,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned LED_N         = 9,
  parameter int unsigned DEB_CYCLES    = 3,
  parameter int unsigned SNOOZE_TIME   = 5,
  parameter int unsigned MAX_SNOOZE    = 3,
  parameter int unsigned ALARM_TIMEOUT = 20
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              start_stop_button,
  input  logic                              set_button,
  input  logic                              snooze_button,
  output logic [CNT_W-1:0]                  ssd_led_out,
  output logic [LED_N-1:0]                  led_out,
  output logic                              alarm_active,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_left
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);
  localparam int unsigned TO_W  = $clog2(ALARM_TIMEOUT + 1);
  localparam int unsigned SN_W  = $clog2(MAX_SNOOZE + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   set_time_q, set_time_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [LED_N-1:0]   led_q, led_d;
  logic [SN_W-1:0]    snooze_q, snooze_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [TO_W-1:0]    tout_q, tout_d;
  logic               alarm_q, alarm_d;
  logic               ss_press, set_press, sn_press;
  logic               tick_c;
  event_e             ev_c;
  logic [31:0]        lvl_c;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .CLK(CLK), .RST_N(RST_N), .btn_n(start_stop_button), .press(ss_press));
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .CLK(CLK), .RST_N(RST_N), .btn_n(set_button), .press(set_press));
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sn (
    .CLK(CLK), .RST_N(RST_N), .btn_n(snooze_button), .press(sn_press));

  assign ev_c   = pick_event(ss_press, sn_press, set_press);
  assign tick_c = ((state_q == RUN) || (state_q == ALARM)) &&
                  (presc_q == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; expiry in RUN outranks a simultaneous pause request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = SET;
      SET:   if (ev_c == EV_START_STOP && set_time_q != '0) state_d = RUN;
      RUN: begin
        if (rem_q == '0)                 state_d = ALARM;
        else if (ev_c == EV_START_STOP)  state_d = PAUSE;
      end
      PAUSE: begin
        if (ev_c == EV_START_STOP)       state_d = RUN;
        else if (ev_c == EV_SET)         state_d = IDLE;
      end
      ALARM: begin
        if (ev_c == EV_START_STOP)                           state_d = IDLE;
        else if (ev_c == EV_SNOOZE && snooze_q != '0)        state_d = SNOOZE;
        else if (tick_c && tout_q == TO_W'(ALARM_TIMEOUT - 1)) state_d = IDLE;
      end
      SNOOZE:  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values, keyed on the state being entered.
  always_comb begin
    set_time_d = set_time_q;
    rem_d      = rem_q;
    snooze_d   = snooze_q;
    led_d      = led_q;
    presc_d    = '0;
    tout_d     = '0;
    alarm_d    = (state_d == ALARM);
    lvl_c      = '0;

    if (((state_d == RUN) || (state_d == ALARM)) && state_d == state_q && !tick_c)
      presc_d = presc_q + PRE_W'(1);
    if (state_q == ALARM && state_d == ALARM)
      tout_d = tick_c ? tout_q + TO_W'(1) : tout_q;

    case (state_d)
      IDLE: begin
        set_time_d = '0;
        rem_d      = '0;
        snooze_d   = SN_W'(MAX_SNOOZE);
      end
      SET: begin
        if (state_q == SET && ev_c == EV_SET && set_time_q < CNT_W'(MAX_SET))
          set_time_d = set_time_q + CNT_W'(1);
        rem_d = set_time_d;
      end
      RUN: begin
        if (state_q == RUN && tick_c && rem_q != '0)
          rem_d = rem_q - CNT_W'(1);
      end
      SNOOZE: begin
        rem_d    = CNT_W'(SNOOZE_TIME);
        snooze_d = snooze_q - SN_W'(1);
      end
      default: ;
    endcase

    lvl_c = (32'(rem_d) < LED_N) ? 32'(rem_d) : LED_N;
    case (state_d)
      IDLE: led_d = '0;
      SET, RUN, PAUSE: begin
        for (int i = 0; i < LED_N; i++) led_d[i] = thermo_bit(lvl_c, 32'(i));
      end
      ALARM: begin
        if (state_q != ALARM) led_d = '1;
        else if (tick_c)      led_d = ~led_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      set_time_q <= '0;
      rem_q      <= '0;
      led_q      <= '0;
      snooze_q   <= SN_W'(MAX_SNOOZE);
      presc_q    <= '0;
      tout_q     <= '0;
      alarm_q    <= 1'b0;
    end else begin
      set_time_q <= set_time_d;
      rem_q      <= rem_d;
      led_q      <= led_d;
      snooze_q   <= snooze_d;
      presc_q    <= presc_d;
      tout_q     <= tout_d;
      alarm_q    <= alarm_d;
    end
  end

  assign ssd_led_out  = rem_q;
  assign led_out      = led_q;
  assign alarm_active = alarm_q;
  assign snooze_left  = snooze_q;

endmodule

// File: tb/tb_alarm_timer_multi.sv
// Scoreboard bench for alarm_timer_multi with a fast 4-cycle tick.
module tb_alarm_timer_multi;

  localparam int unsigned CD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ss_n, set_n, sn_n;
  logic [3:0] ssd;
  logic [8:0] led;
  logic       alarm;
  logic [1:0] snz;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned sel_q[$];
  int unsigned exp_q[$];
  string       tag_q[$];

  localparam int unsigned S_SSD = 0, S_LED = 1, S_ALM = 2, S_SNZ = 3;

  alarm_timer_multi #(.CLK_DIV(CD)) dut (
    .CLK(clk), .RST_N(rst_n),
    .start_stop_button(ss_n), .set_button(set_n), .snooze_button(sn_n),
    .ssd_led_out(ssd), .led_out(led), .alarm_active(alarm), .snooze_left(snz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int unsigned sel);
    case (sel)
      S_SSD:   return 32'(ssd);
      S_LED:   return 32'(led);
      S_ALM:   return 32'(alarm);
      default: return 32'(snz);
    endcase
  endfunction

  task automatic sb_push(input int unsigned sel, input string tag, input int unsigned val);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic sb_drain();
    while (sel_q.size() > 0) begin
      int unsigned s;
      int unsigned e;
      string       t;
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, observe(s), 32'(e));
    end
  endtask

  // m[0]=start_stop, m[1]=set, m[2]=snooze; returns just after the reacting edge
  task automatic press(input logic [2:0] m);
    if (m[0]) ss_n = 1'b0;
    if (m[1]) set_n = 1'b0;
    if (m[2]) sn_n = 1'b0;
    repeat (4) @(negedge clk);
    ss_n = 1'b1; set_n = 1'b1; sn_n = 1'b1;
  endtask

  task automatic press_gap(input logic [2:0] m);
    press(m);
    @(negedge clk);
  endtask

  task automatic wait_alarm(input int budget);
    int n;
    n = 0;
    while (!alarm && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("alarm_wait", 32'(alarm), 32'd1);
  endtask

  initial begin
    int dev, hi, ch;
    logic [8:0] prev;
    rst_n = 1'b0; ss_n = 1'b1; set_n = 1'b1; sn_n = 1'b1;
    repeat (2) @(negedge clk);
    sb_push(S_SSD, "rst_ssd", 0); sb_push(S_LED, "rst_led", 0);
    sb_push(S_ALM, "rst_alarm", 0); sb_push(S_SNZ, "rst_snooze", 3);
    sb_drain();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Set range saturation and full countdown
    repeat (12) press_gap(3'b010);
    sb_push(S_SSD, "set_sat", 9); sb_push(S_LED, "set_led", 9'h1FF);
    sb_drain();
    press(3'b001);
    sb_push(S_SSD, "run_start", 9); sb_drain();
    repeat (35) @(negedge clk);
    sb_push(S_SSD, "run_35", 1); sb_push(S_ALM, "run_35_alarm", 0); sb_drain();
    @(negedge clk);
    sb_push(S_SSD, "run_zero", 0); sb_push(S_ALM, "zero_no_alarm", 0); sb_drain();
    @(negedge clk);
    sb_push(S_ALM, "alarm_edge", 1); sb_push(S_LED, "alarm_led", 9'h1FF); sb_drain();

    // Snooze limit
    for (int k = 0; k < 3; k++) begin
      press(3'b100);
      sb_push(S_SSD, "snooze_rem", 5); sb_push(S_SNZ, "snooze_left", 2 - k);
      sb_push(S_ALM, "snooze_alarm", 0); sb_drain();
      wait_alarm(40);
    end
    press(3'b100);
    sb_push(S_ALM, "snooze4_alarm", 1); sb_push(S_SNZ, "snooze4_left", 0);
    sb_push(S_SSD, "snooze4_ssd", 0); sb_drain();
    press(3'b001);
    sb_push(S_SSD, "idle_ssd", 0); sb_push(S_LED, "idle_led", 0);
    sb_push(S_ALM, "idle_alarm", 0); sb_push(S_SNZ, "idle_snooze", 3); sb_drain();
    @(negedge clk);

    // Bounce rejection and debounced press latency
    set_n = 1'b0;
    repeat (2) @(negedge clk);
    set_n = 1'b1;
    repeat (5) @(negedge clk);
    sb_push(S_SSD, "bounce", 0); sb_drain();
    set_n = 1'b0;
    repeat (3) @(negedge clk);
    sb_push(S_SSD, "deb_early", 0); sb_drain();
    @(negedge clk);
    sb_push(S_SSD, "deb_edge4", 1); sb_drain();
    repeat (6) @(negedge clk);
    set_n = 1'b1;
    repeat (3) @(negedge clk);
    sb_push(S_SSD, "deb_once", 1); sb_drain();

    // Pause and resume
    repeat (4) press_gap(3'b010);
    sb_push(S_SSD, "pause_set", 5); sb_push(S_LED, "pause_set_led", 9'h01F); sb_drain();
    press(3'b001);
    repeat (6) @(negedge clk);
    press(3'b001);
    sb_push(S_SSD, "paused", 3); sb_push(S_LED, "paused_led", 9'h007); sb_drain();
    dev = 0;
    repeat (100) begin
      @(negedge clk);
      if (ssd != 4'd3) dev++;
    end
    chk("pause_hold", 32'(dev), 32'd0);
    press(3'b001);
    repeat (3) @(negedge clk);
    sb_push(S_SSD, "resume_pre", 3); sb_drain();
    @(negedge clk);
    sb_push(S_SSD, "resume_dec", 2); sb_drain();
    wait_alarm(40);

    // Simultaneous start_stop+snooze: start_stop wins
    press(3'b101);
    sb_push(S_ALM, "simul_alarm", 0); sb_push(S_SSD, "simul_ssd", 0);
    sb_push(S_SNZ, "simul_snooze", 3); sb_drain();
    @(negedge clk);

    // Alarm auto-timeout
    press_gap(3'b010);
    press(3'b001);
    wait_alarm(20);
    hi = 0; ch = 0; prev = '0;
    for (int i = 0; i < 200; i++) begin
      if (!alarm) break;
      hi++;
      if (led != prev) ch++;
      prev = led;
      @(negedge clk);
    end
    chk("timeout_cycles", 32'(hi), 32'(20 * CD));
    chk("timeout_toggles", 32'(ch), 32'd20);
    sb_push(S_LED, "timeout_led", 0); sb_push(S_SNZ, "timeout_snooze", 3); sb_drain();
    @(negedge clk);

    // Asynchronous reset mid-RUN
    repeat (4) press_gap(3'b010);
    press(3'b001);
    repeat (2) @(negedge clk);
    sb_push(S_SSD, "midrun_rem", 4); sb_drain();
    rst_n = 1'b0;
    #1;
    sb_push(S_SSD, "arst_ssd", 0); sb_push(S_LED, "arst_led", 0);
    sb_push(S_ALM, "arst_alarm", 0); sb_push(S_SNZ, "arst_snooze", 3); sb_drain();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
